// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: two on-chip line buffers feed a sliding window,
// producing one saturated |gx|+|gy| (or thresholded) pixel per accepted input pixel.
module sobel_stream #(
   parameter int IMG_W    = 1600,
   parameter int IMG_H    = 900,
   parameter int PIX_W    = 8,
   parameter int MAG_MODE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_data,
   input  logic [PIX_W-1:0] thresh,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_data,
   output logic             out_sof,
   output logic             out_eol,
   output logic             out_eof
);

   localparam int NPIX = IMG_W * IMG_H;
   localparam int KW   = $clog2(NPIX);
   localparam int XW   = $clog2(IMG_W);
   localparam int YW   = $clog2(IMG_H);
   localparam int GW   = PIX_W + 4;

   localparam logic [KW-1:0] K_FILL_END = KW'(IMG_W);
   localparam logic [KW-1:0] K_LAST     = KW'(NPIX - 1);
   localparam logic [XW-1:0] X_LAST     = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST     = YW'(IMG_H - 1);

   typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

   state_t            state;
   logic [KW-1:0]     k;
   logic [XW-1:0]     in_x;
   logic [XW-1:0]     out_x;
   logic [YW-1:0]     out_y;
   logic [PIX_W-1:0]  thresh_q;

   logic [PIX_W-1:0]  line0 [IMG_W];
   logic [PIX_W-1:0]  line1 [IMG_W];

   logic [PIX_W-1:0]  c1_t, c1_m, c1_b;
   logic [PIX_W-1:0]  c2_t, c2_m, c2_b;
   logic [PIX_W-1:0]  n_t, n_m, n_b;

   logic              accept;
   logic              load;
   logic signed [GW-1:0] gx, gy;
   logic [GW-1:0]     abs_gx, abs_gy, mag;
   logic [PIX_W-1:0]  mag_sat, edge_pix, pix_next;
   logic              border;

   function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
      return $signed({4'b0000, p});
   endfunction

   always_comb begin
      in_ready = 1'b0;
      if (!rst) begin
         case (state)
            FILL:    in_ready = 1'b1;
            RUN:     in_ready = !out_valid || out_ready;
            default: in_ready = 1'b0;
         endcase
      end
   end

   assign accept = in_valid && in_ready;

   // FLUSH stops loading once the eof pixel is sitting in the output register.
   assign load = (state == RUN && accept) ||
                 (state == FLUSH && (!out_valid || (out_ready && !out_eof)));

   // Incoming column of the window: two lines above from the buffers, current pixel below.
   assign n_t = line1[in_x];
   assign n_m = line0[in_x];
   assign n_b = in_data;

   always_comb begin
      gx = (ext(n_t) + ext(n_m) + ext(n_m) + ext(n_b))
         - (ext(c1_t) + ext(c1_m) + ext(c1_m) + ext(c1_b));
      gy = (ext(c1_t) + ext(c2_t) + ext(c2_t) + ext(n_t))
         - (ext(c1_b) + ext(c2_b) + ext(c2_b) + ext(n_b));
      abs_gx  = $unsigned(gx[GW-1] ? -gx : gx);
      abs_gy  = $unsigned(gy[GW-1] ? -gy : gy);
      mag     = abs_gx + abs_gy;
      mag_sat = (|mag[GW-1:PIX_W]) ? '1 : mag[PIX_W-1:0];
      if (MAG_MODE == 1)
         edge_pix = (mag_sat >= thresh_q) ? '1 : '0;
      else
         edge_pix = mag_sat;
      border   = (out_x == '0) || (out_x == X_LAST) || (out_y == '0) || (out_y == Y_LAST);
      pix_next = border ? '0 : edge_pix;
   end

   // Line buffers and window columns hold only pixel data, so they need no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         line0[in_x] <= in_data;
         line1[in_x] <= n_m;
         c1_t <= c2_t;
         c1_m <= c2_m;
         c1_b <= c2_b;
         c2_t <= n_t;
         c2_m <= n_m;
         c2_b <= n_b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FILL;
         k         <= '0;
         in_x      <= '0;
         out_x     <= '0;
         out_y     <= '0;
         thresh_q  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
         out_eof   <= 1'b0;
      end else begin
         if (accept) begin
            in_x <= (in_x == X_LAST) ? '0 : in_x + 1'b1;
            if (k == '0)
               thresh_q <= thresh;
         end

         // Output coordinates run independently of the input and wrap to (0,0) after eof.
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= pix_next;
            out_sof   <= (out_x == '0) && (out_y == '0);
            out_eol   <= (out_x == X_LAST);
            out_eof   <= (out_x == X_LAST) && (out_y == Y_LAST);
            if (out_x == X_LAST) begin
               out_x <= '0;
               out_y <= (out_y == Y_LAST) ? '0 : out_y + 1'b1;
            end else begin
               out_x <= out_x + 1'b1;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            FILL: begin
               if (accept) begin
                  k <= k + 1'b1;
                  if (k == K_FILL_END)
                     state <= RUN;
               end
            end
            RUN: begin
               if (accept) begin
                  if (k == K_LAST) begin
                     k     <= '0;
                     state <= FLUSH;
                  end else begin
                     k <= k + 1'b1;
                  end
               end
            end
            FLUSH: begin
               if (out_valid && out_ready && out_eof)
                  state <= FILL;
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: doc/sobel_stream.md
# sobel_stream

Synthesizable streaming successor to the frame-buffer Sobel model. It accepts raster-order pixels over a valid/ready handshake and stores two image lines on chip. It emits one gradient-magnitude pixel per input pixel, using either saturated L1 mode or binary threshold mode. It sits between the pixel source (camera/DMA unpacker) and the edge-map sink, and must match the frame-level golden model bit-exactly in L1 mode.

## Interface
- IMG_W, 1600, pixels per line (≥4)
- IMG_H, 900, lines per frame (≥3)
- PIX_W, 8, bits per pixel, in and out
- MAG_MODE, 0, 0 = saturated |gx|+|gy|; 1 = binary threshold output
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input pixel valid
- in_ready  out  1  block accepts input pixel this cycle
- in_data  in  PIX_W  input pixel, raster order, unsigned
- thresh  in  PIX_W  threshold, used only when MAG_MODE=1
- out_valid  out  1  output pixel valid
- out_ready  in  1  sink accepts output pixel
- out_data  out  PIX_W  edge pixel
- out_sof  out  1  qualifies out_valid; pixel (0,0)
- out_eol  out  1  qualifies out_valid; pixel x==IMG_W-1
- out_eof  out  1  qualifies out_valid; pixel (IMG_W-1, IMG_H-1)

## Operation
- Input index k counts 0..IMG_W*IMG_H-1 on each accepted input beat (in_valid && in_ready). The frame is implicit, with no input framing signals.
- Two line buffers (IMG_W x PIX_W, single-port RAM-inferable) plus a 3x3 window register. The window is centred on output pixel k-(IMG_W+1).
- States:
  - FILL (k < IMG_W+1): accepted beats produce no output.
  - RUN: each accepted beat produces output index k-(IMG_W+1).
  - FLUSH: entered after input k = IMG_W*IMG_H-1 is accepted. The block generates the remaining IMG_W+1 outputs without input. After the out_eof beat is accepted, it goes to FILL with k=0.
- Border outputs (x==0, x==IMG_W-1, y==0, y==IMG_H-1) are forced to 0. All FLUSH outputs are therefore 0. Line-buffer contents never need clearing.
- gx = (p02+2p12+p22) - (p00+2p10+p20); gy = (p00+2p01+p02) - (p20+2p21+p22). Both are signed PIX_W+3 bits plus sign.
- mag = |gx|+|gy| at PIX_W+4 bits unsigned. It saturates to 2^PIX_W-1.
- When MAG_MODE=1: out_data = (mag_sat ≥ thresh_q) ? all-ones : 0.
  - thresh_q is captured from thresh on the beat accepting k=0. It is constant for the frame.
- out_sof/out_eol/out_eof are computed from the output coordinate, not the input coordinate.

## Timing
- Reset values: out_valid=0, out_data=0, out_sof/eol/eof=0, state=FILL, k=0, output counters 0, thresh_q=0.
- in_ready is combinational and equals 0 while rst=1. Otherwise it is:
  - in FILL: 1
  - in RUN: !out_valid || out_ready
  - in FLUSH: 0
- Latency: the output for input beat k (k ≥ IMG_W+1) is presented with out_valid=1 on the cycle after acceptance.
- In FLUSH, a new output is loaded on any cycle where !out_valid || out_ready.
- Throughput: 1 pixel/cycle sustained when out_ready=1. There are no bubbles between frames except the FLUSH period of IMG_W+1 cycles.
- Handshake: out_data and flags stay stable while out_valid && !out_ready. out_valid never drops without a transfer.
- Simultaneous events: acceptance of the last input and an output transfer in the same cycle is legal. The state goes to FLUSH and the new output is loaded.
- Mid-frame reset: the partial frame is discarded, and no further output is produced for it. The next accepted pixel is (0,0) of a new frame.

## Test plan
- Vertical step, IMG_W=8, IMG_H=6, MAG_MODE=0, columns 0-3 = 0 and 4-7 = 100, out_ready=1 -> interior x=3 and x=4 output 255 (gx=400 saturated), all other pixels 0; exactly 48 outputs; sof on the first, eol every 8th, eof on the 48th.
- Horizontal ramp, row y = 10*y, same size -> interior pixels 80, borders 0; output matches the frame-level golden model bit-exactly.
- Threshold mode, ramp image -> thresh=81 gives all 0; thresh=80 gives interior 255, borders 0.
- Threshold capture: thresh changes from 80 to 200 mid-frame -> frame output unchanged; the next frame uses 200.
- Backpressure, ramp image with out_ready toggled pseudo-randomly (50%) -> identical output sequence; in_ready=0 whenever out_valid && !out_ready in RUN; FLUSH emits 9 zeros with in_ready=0; back-to-back frames correct.
- Reset after 20 accepted pixels, then a full step frame -> no stale output; exactly 48 outputs matching scenario 1.
